// File: rtl/exu_wb_ctrl.sv
// exu_wb_ctrl: execute / memory / write-back sequencer behind the IDU.
// Accepts one decoded instruction at a time, runs the optional memory
// request/response exchange and produces a single-cycle GPR write-back.
// Optional feature: define EXU_WB_TIMEOUT_EN to abort a load whose
// response does not arrive within TIMEOUT_CYC cycles (err pulse, no write).
module exu_wb_ctrl #(
    parameter int unsigned ISA_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_ebreak,
    input  logic [1:0]           ld_kind,
    input  logic [4:0]           rd,
    input  logic                 wr_req,
    input  logic [ISA_WIDTH-1:0] alu_result,
    input  logic [ISA_WIDTH-1:0] st_data,
    input  logic [3:0]           st_mask,
    output logic                 mem_req_valid,
    output logic                 mem_req_wen,
    output logic [ISA_WIDTH-1:0] mem_req_addr,
    output logic [ISA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]           mem_req_wmask,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [ISA_WIDTH-1:0] mem_resp_data,
    output logic                 gpr_we,
    output logic [4:0]           gpr_waddr,
    output logic [ISA_WIDTH-1:0] gpr_wdata,
    output logic                 done,
    output logic                 halted,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    state_t state;

    // Instruction latches captured on accept
    logic                 is_load_q;
    logic                 is_store_q;
    logic [1:0]           ld_kind_q;
    logic [4:0]           rd_q;
    logic                 wr_req_q;
    logic [ISA_WIDTH-1:0] alu_q;
    logic [ISA_WIDTH-1:0] st_data_q;
    logic [3:0]           st_mask_q;

`ifdef EXU_WB_TIMEOUT_EN
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tcnt;
`endif

    // Load result formatting: lw sign-extends the low word, lbu zero-extends
    // the low byte, reserved kinds write zero.
    function automatic logic [ISA_WIDTH-1:0] fmt_load(input logic [1:0]           kind,
                                                      input logic [ISA_WIDTH-1:0] data);
        logic [31:0] word;
        word = data[31:0];
        case (kind)
            2'd0:    fmt_load = ISA_WIDTH'($signed(word));
            2'd1:    fmt_load = ISA_WIDTH'(word[7:0]);
            default: fmt_load = '0;
        endcase
    endfunction

    // GPR write enable: requested, not a store, and never to x0
    function automatic logic wb_enable(input logic       wr,
                                       input logic       st,
                                       input logic [4:0] dst);
        wb_enable = wr && !st && (dst != 5'd0);
    endfunction

    // Memory request fields come straight from the accept-time latches
    assign mem_req_addr  = alu_q;
    assign mem_req_wdata = st_data_q;
    assign mem_req_wmask = st_mask_q;

    // Sequencer: state, latches and all registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            is_load_q     <= 1'b0;
            is_store_q    <= 1'b0;
            ld_kind_q     <= '0;
            rd_q          <= '0;
            wr_req_q      <= 1'b0;
            alu_q         <= '0;
            st_data_q     <= '0;
            st_mask_q     <= '0;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            gpr_we        <= 1'b0;
            gpr_waddr     <= '0;
            gpr_wdata     <= '0;
            done          <= 1'b0;
            halted        <= 1'b0;
            err           <= 1'b0;
`ifdef EXU_WB_TIMEOUT_EN
            tcnt          <= '0;
`endif
        end else begin
            gpr_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_load_q  <= is_load;
                        is_store_q <= is_store;
                        ld_kind_q  <= ld_kind;
                        rd_q       <= rd;
                        wr_req_q   <= wr_req;
                        alu_q      <= alu_result;
                        st_data_q  <= st_data;
                        st_mask_q  <= st_mask;
                        in_ready   <= 1'b0;
                        if (is_ebreak) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (is_load || is_store) begin
                            state         <= MEM_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= is_store;
                        end else begin
                            // WB outputs are loaded from the live inputs here so
                            // the write-back appears on the cycle after accept.
                            state     <= WB;
                            gpr_we    <= wb_enable(wr_req, is_store, rd);
                            gpr_waddr <= rd;
                            gpr_wdata <= alu_result;
                            done      <= 1'b1;
                        end
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_wen   <= 1'b0;
                        if (is_load_q && !is_store_q) begin
                            state <= MEM_WAIT;
`ifdef EXU_WB_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            state     <= WB;
                            gpr_we    <= wb_enable(wr_req_q, is_store_q, rd_q);
                            gpr_waddr <= rd_q;
                            gpr_wdata <= alu_q;
                            done      <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        state     <= WB;
                        gpr_we    <= wb_enable(wr_req_q, is_store_q, rd_q);
                        gpr_waddr <= rd_q;
                        gpr_wdata <= fmt_load(ld_kind_q, mem_resp_data);
                        done      <= 1'b1;
                    end
`ifdef EXU_WB_TIMEOUT_EN
                    else if (tcnt == TCNT_LAST) begin
                        // Abort reuses the WB cycle with err instead of done
                        tcnt      <= tcnt + 8'd1;
                        state     <= WB;
                        gpr_waddr <= rd_q;
                        err       <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
`endif
                end
                WB: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exu_wb_ctrl.sv
// tb_exu_wb_ctrl: randomized scoreboard bench for exu_wb_ctrl.
// The driver predicts every write-back and memory request from the
// instruction rules and pushes them into queues; independent monitors
// pop and compare whenever the DUT shows activity.
module tb_exu_wb_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_load;
    logic        is_store;
    logic        is_ebreak;
    logic [1:0]  ld_kind;
    logic [4:0]  rd;
    logic        wr_req;
    logic [31:0] alu_result;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        done;
    logic        halted;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        dn;
        logic        er;
        bit          chk_data;
        int          at;
    } wb_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mr_t;

    wb_t wbq[$];
    mr_t memq[$];

    exu_wb_ctrl #(.ISA_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
        .ld_kind(ld_kind), .rd(rd), .wr_req(wr_req), .alu_result(alu_result),
        .st_data(st_data), .st_mask(st_mask),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .done(done), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference load formatting: word as-is for lw, low byte for lbu, else 0
    function automatic logic [31:0] ref_load(input logic [1:0] kind, input logic [31:0] d);
        if (kind == 2'd0) return d;
        if (kind == 2'd1) return d % 256;
        return 32'd0;
    endfunction

    // Write-back monitor
    always @(negedge clk) begin
        if (!rst && (gpr_we || done || err)) begin
            if (wbq.size() == 0) begin
                chk("wb_unexpected", {gpr_we, done, err, gpr_waddr, gpr_wdata}, '0);
            end else begin
                wb_t e;
                e = wbq.pop_front();
                chk("wb", {gpr_we, done, err, 32'(cyc),
                           e.chk_data ? gpr_waddr : 5'd0, e.chk_data ? gpr_wdata : 32'd0},
                          {e.we, e.dn, e.er, 32'(e.at),
                           e.chk_data ? e.waddr : 5'd0, e.chk_data ? e.wdata : 32'd0});
            end
        end
    end

    // Memory request monitor: every cycle the bench offers ready must be a handshake
    always @(negedge clk) begin
        if (!rst && mem_req_ready) begin
            if (memq.size() == 0) begin
                chk("mem_unexpected", {mem_req_valid}, '0);
            end else begin
                mr_t m;
                m = memq.pop_front();
                chk("mem_req", {mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
                               {1'b1, m.wen, m.addr, m.wdata, m.mask});
            end
        end
    end

    task automatic quiet();
        in_valid       = 1'b0;
        is_ebreak      = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    // Random noise on inputs the DUT must ignore in its current state
    task automatic junk(input bit with_resp);
        in_valid       = 1'($urandom_range(0, 1));
        is_load        = 1'($urandom_range(0, 1));
        is_store       = 1'($urandom_range(0, 1));
        is_ebreak      = 1'($urandom_range(0, 1));
        ld_kind        = 2'($urandom_range(0, 3));
        rd             = 5'($urandom);
        wr_req         = 1'($urandom_range(0, 1));
        alu_result     = $urandom;
        st_data        = $urandom;
        st_mask        = 4'($urandom);
        mem_resp_valid = with_resp ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_resp_data  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_in_ready", {in_ready}, {1'b1});
    endtask

    task automatic drive_instr(input int kind, input logic [1:0] lk, input logic [4:0] r_d,
                               input logic wr, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [3:0] sm);
        in_valid       = 1'b1;
        is_load        = (kind == 1);
        is_store       = (kind == 2);
        is_ebreak      = 1'b0;
        ld_kind        = lk;
        rd             = r_d;
        wr_req         = wr;
        alu_result     = alu;
        st_data        = sd;
        st_mask        = sm;
        mem_resp_valid = 1'b0;
    endtask

    // kind: 0 ALU, 1 load, 2 store; w = request wait, r = response wait
    task automatic issue(input int kind, input logic [1:0] lk, input logic [4:0] r_d,
                         input logic wr, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [3:0] sm, input int w, input int r,
                         input logic [31:0] rdat, input bit no_resp);
        int  a;
        wb_t e;
        mr_t m;
        wait_idle();
        drive_instr(kind, lk, r_d, wr, alu, sd, sm);
        @(posedge clk); #1;
        a = cyc;
        if (kind == 0) begin
            e = '{wr && r_d != 0, r_d, alu, 1'b1, 1'b0, 1'b1, a};
            wbq.push_back(e);
            junk(1'b1);
            @(posedge clk); #1;
            quiet();
            return;
        end
        m = '{kind == 2, alu, sd, sm};
        memq.push_back(m);
        for (int i = 0; i < w; i++) begin
            junk(1'b1);
            chk("req_hold", {mem_req_valid, mem_req_wen, mem_req_addr}, {1'b1, kind == 2, alu});
            @(posedge clk); #1;
        end
        quiet();
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        if (kind == 2) begin
            e = '{1'b0, r_d, alu, 1'b1, 1'b0, 1'b1, a + w + 1};
            wbq.push_back(e);
            junk(1'b1);
            @(posedge clk); #1;
            quiet();
        end else if (no_resp) begin
            e = '{1'b0, r_d, 32'd0, 1'b0, 1'b1, 1'b0, a + w + 1 + TO};
            wbq.push_back(e);
            for (int i = 0; i < TO; i++) begin
                junk(1'b0);
                @(posedge clk); #1;
            end
            quiet();
            @(posedge clk); #1;
            chk("timeout_in_ready", {in_ready, gpr_we}, {1'b1, 1'b0});
        end else begin
            for (int i = 0; i < r; i++) begin
                junk(1'b0);
                @(posedge clk); #1;
            end
            in_valid       = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'b1;
            mem_resp_data  = rdat;
            e = '{wr && r_d != 0, r_d, ref_load(lk, rdat), 1'b1, 1'b0, 1'b1, a + w + r + 2};
            wbq.push_back(e);
            @(posedge clk); #1;
            junk(1'b1);
            @(posedge clk); #1;
            quiet();
        end
    endtask

    task automatic check_reset(input string name);
        chk(name, {in_ready, gpr_we, done, err, halted, mem_req_valid, mem_req_wen,
                   mem_req_wmask, gpr_waddr, mem_req_addr, mem_req_wdata, gpr_wdata},
                  {1'b1, 6'b0, 4'b0, 5'b0, 96'b0});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic random_instr();
        int          k;
        logic [4:0]  r_d;
        k   = $urandom_range(0, 2);
        r_d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        issue(k, 2'($urandom_range(0, 3)), r_d, 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        is_load = 1'b0; is_store = 1'b0; ld_kind = '0; rd = '0; wr_req = 1'b0;
        alu_result = '0; st_data = '0; st_mask = '0; mem_resp_data = '0;
        mem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset_state");

        // addi x5, 0x2A
        issue(0, 2'd0, 5'd5, 1'b1, 32'h2A, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);
        chk("alu_then_in_ready", {in_ready}, {1'b1});
        // lw x3 with delayed request and response
        issue(1, 2'd0, 5'd3, 1'b1, 32'h8000_0010, 32'h0, 4'h0, 2, 3, 32'hFFFF_FF80, 1'b0);
        // lbu x4 and lbu x0
        issue(1, 2'd1, 5'd4, 1'b1, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 32'h1234_56F0, 1'b0);
        issue(1, 2'd1, 5'd0, 1'b1, 32'h0000_0200, 32'h0, 4'h0, 1, 1, 32'h1234_56F0, 1'b0);
        // reserved load kind writes zero
        issue(1, 2'd3, 5'd9, 1'b1, 32'h0000_0300, 32'h0, 4'h0, 0, 2, 32'hCAFE_F00D, 1'b0);
        // sw with request held for three cycles
        issue(2, 2'd0, 5'd7, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h0, 1'b0);

        // Reset while waiting for a load response, then a late response
        wait_idle();
        drive_instr(1, 2'd0, 5'd9, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
        @(posedge clk); #1;
        quiet();
        memq.push_back('{1'b0, 32'h0000_0040, 32'h0, 4'h0});
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        do_reset();
        check_reset("reset_mem_wait");
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111_2222;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("late_resp_idle", {in_ready, gpr_we, done}, {1'b1, 1'b0, 1'b0});

        // Reset while a store request is still pending
        wait_idle();
        drive_instr(2, 2'd0, 5'd1, 1'b0, 32'h0000_0080, 32'h5555_AAAA, 4'h3);
        @(posedge clk); #1;
        quiet();
        chk("req_pending", {mem_req_valid, mem_req_wen}, {1'b1, 1'b1});
        do_reset();
        check_reset("reset_mem_req");

        for (int n = 0; n < 150; n++) random_instr();

        // ebreak halts until reset; further instructions are ignored
        wait_idle();
        drive_instr(0, 2'd0, 5'd2, 1'b1, 32'h0, 32'h0, 4'h0);
        is_ebreak = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            chk("halted", {halted, in_ready, mem_req_valid, gpr_we, done},
                          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
            junk(1'b1);
            in_valid  = 1'b1;
            is_ebreak = 1'b0;
            @(posedge clk); #1;
        end
        quiet();
        do_reset();
        check_reset("reset_after_halt");

`ifdef EXU_WB_TIMEOUT_EN
        issue(1, 2'd0, 5'd6, 1'b1, 32'h0000_0500, 32'h0, 4'h0, 1, 0, 32'h0, 1'b1);
`endif

        for (int n = 0; n < 30; n++) random_instr();

        repeat (4) @(posedge clk);
        #1 chk("queues_drained", {32'(wbq.size()), 32'(memq.size())}, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/exu_wb_ctrl.md
EXU_WB_CTRL -- requirements
Module: exu_wb_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255; MEM_WAIT cycles before timeout abort (used only with EXU_WB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1 / in_ready output 1: decoded-instruction handshake from IDU.
REQ-005 SHALL have inputs is_load 1, is_store 1, is_ebreak 1, ld_kind 2 (0=lw, 1=lbu, 2-3 reserved), rd 5, wr_req 1 (decoded GPR write enable).
REQ-006 SHALL have inputs alu_result ISA_WIDTH (address/result), st_data ISA_WIDTH, st_mask 4.
REQ-007 SHALL have outputs mem_req_valid 1, mem_req_wen 1, mem_req_addr ISA_WIDTH, mem_req_wdata ISA_WIDTH, mem_req_wmask 4; input mem_req_ready 1.
REQ-008 SHALL have inputs mem_resp_valid 1, mem_resp_data ISA_WIDTH.
REQ-009 SHALL have outputs gpr_we 1, gpr_waddr 5, gpr_wdata ISA_WIDTH, done 1, halted 1, err 1.

Function
REQ-010 SHALL implement states IDLE, MEM_REQ, MEM_WAIT, WB, HALT.
REQ-011 IDLE: in_ready=1; on in_valid SHALL latch all REQ-005/006 inputs in the same edge.
REQ-012 From IDLE on accept: is_ebreak -> HALT; else is_load or is_store -> MEM_REQ; else -> WB.
REQ-013 MEM_REQ: mem_req_valid=1, mem_req_wen=latched is_store, addr/wdata/wmask from latches, stable until mem_req_ready; mem_req_valid and mem_req_ready both 1 on an edge -> MEM_WAIT for load, WB for store.
REQ-014 MEM_WAIT: on mem_resp_valid SHALL latch data -> WB; mem_resp_valid outside MEM_WAIT SHALL be ignored.
REQ-015 Load data: lw -> mem_resp_data[31:0] sign-extended to ISA_WIDTH; lbu -> [7:0] zero-extended; reserved ld_kind -> 0.
REQ-016 WB is one cycle: gpr_we = latched wr_req AND NOT is_store AND rd!=0; gpr_wdata = load data for loads, latched alu_result otherwise; done=1; next state IDLE.
REQ-017 in_ready SHALL be 0 in every state except IDLE; no new instruction during WB (accept earliest on the following cycle).
REQ-018 Latency accept->WB: ALU op 1 cycle; store 1 + request wait; load 2 + request wait + response wait.
REQ-019 HALT: sticky, halted=1, in_ready=0, no memory or GPR activity until rst.
REQ-020 gpr_we, done, err, mem_req_valid SHALL be 0 in every state not listed as driving them.

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE from any state, including MEM_REQ/MEM_WAIT mid-transaction, discarding the pending instruction.
REQ-022 After reset all outputs 0 except in_ready=1; latches and timeout counter 0.
REQ-023 A mem_resp_valid arriving after a reset-aborted load SHALL be ignored (state IDLE).

Configuration
REQ-024 Macro EXU_WB_TIMEOUT_EN defined: 8-bit counter cleared on MEM_WAIT entry, increments each MEM_WAIT cycle without mem_resp_valid; on reaching TIMEOUT_CYC -> err=1 one cycle, no GPR write, done=0, next IDLE; response on the same cycle as terminal count wins (normal WB).
REQ-025 Macro undefined: no counter, err tied 0, MEM_WAIT waits indefinitely.

Verification
REQ-026 addi (wr_req=1, rd=5, alu_result=0x2A), in_valid one cycle -> next cycle gpr_we=1, gpr_waddr=5, gpr_wdata=0x2A, done=1; following cycle in_ready=1.
REQ-027 lw rd=3, addr 0x80000010, mem_req_ready delayed 2 cycles, resp 0xFFFFFF80 after 3 more -> gpr_wdata sign-extended 0x...FFFFFF80, one gpr_we pulse.
REQ-028 lbu rd=4, resp 0x123456F0 -> gpr_wdata=0xF0; same with rd=0 -> gpr_we=0, done=1.
REQ-029 sw addr 0x100, st_data 0xDEADBEEF, mask 0xF -> mem_req_wen=1 held until ready; WB gpr_we=0, done=1.
REQ-030 rst asserted during MEM_WAIT, then mem_resp_valid -> state IDLE, no gpr_we; ebreak -> halted=1, later in_valid ignored until rst.
REQ-031 With EXU_WB_TIMEOUT_EN, load with no response -> err=1 exactly TIMEOUT_CYC cycles after MEM_WAIT entry, no gpr_we, then in_ready=1.
